// File: rtl/fcore_efi_arbiter_if.sv
// Handshake bundle between the EFI arbiter, the fCore request/done lines and the shared EFI unit.
// The master modport is the arbiter's view; the slave modport is the cores/EFI-unit side.
interface fcore_efi_arbiter_if #(
  parameter int N_CORES = 4
);
  logic [N_CORES-1:0]         core_efi_start;
  logic [N_CORES-1:0]         core_efi_done;
  logic                       efi_start;
  logic                       efi_done;
  logic [$clog2(N_CORES)-1:0] efi_core_id;

  modport master (
    input  core_efi_start,
    input  efi_done,
    output core_efi_done,
    output efi_start,
    output efi_core_id
  );

  modport slave (
    output core_efi_start,
    output efi_done,
    input  core_efi_done,
    input  efi_start,
    input  efi_core_id
  );
endinterface

// File: rtl/fcore_efi_arbiter.sv
// Round-robin sharing of one EFI unit among N_CORES fCores, with a watchdog that turns a hung unit into a sticky fault.
// Request to efi_start takes 2 cycles; done reaches the core 1 cycle after efi_done; cores stall themselves until done.
module fcore_efi_arbiter #(
  parameter int N_CORES       = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  fcore_efi_arbiter_if.master        efi_if,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_cycles,
  input  logic                       clear_fault,
  output logic                       busy,
  output logic                       fault,
  output logic [$clog2(N_CORES)-1:0] fault_core
);
  localparam int IDW = $clog2(N_CORES);
  localparam int SW  = IDW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT,
    ST_FAULT
  } state_e;

  state_e                   state_q, state_d;
  logic [N_CORES-1:0]       pending_q, pending_d;
  logic [N_CORES-1:0]       pend_clr;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]           efi_core_id_q, efi_core_id_d;
  logic [TIMEOUT_WIDTH-1:0] counter_q, counter_d;
  logic [N_CORES-1:0]       core_efi_done_q, core_efi_done_d;
  logic                     busy_q, busy_d;
  logic                     fault_q, fault_d;
  logic [IDW-1:0]           fault_core_q, fault_core_d;

  logic [IDW-1:0]           sel_idx;
  logic                     sel_found;
  logic [IDW-1:0]           next_ptr;
  logic                     timeout_hit;

  // First pending core at or after rr_ptr, wrapping modulo N_CORES.
  always_comb begin
    logic [SW-1:0] cand;
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int j = 0; j < N_CORES; j++) begin
      cand = {1'b0, rr_ptr_q} + SW'(j);
      if (cand >= SW'(N_CORES)) begin
        cand = cand - SW'(N_CORES);
      end
      if (!sel_found && pending_q[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  assign next_ptr    = (efi_core_id_q == IDW'(N_CORES - 1)) ? '0 : efi_core_id_q + IDW'(1);
  assign timeout_hit = (timeout_cycles != '0) &&
                       (counter_q == (timeout_cycles - TIMEOUT_WIDTH'(1)));

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    efi_core_id_d   = efi_core_id_q;
    counter_d       = counter_q;
    core_efi_done_d = '0;
    fault_d         = fault_q;
    fault_core_d    = fault_core_q;
    pend_clr        = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          efi_core_id_d = sel_idx;
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        counter_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (counter_q != '1) begin
          counter_d = counter_q + TIMEOUT_WIDTH'(1);
        end
        // A done arriving on the limit cycle still counts as a completion.
        if (efi_if.efi_done) begin
          core_efi_done_d[efi_core_id_q] = 1'b1;
          pend_clr[efi_core_id_q]        = 1'b1;
          rr_ptr_d                       = next_ptr;
          state_d                        = ST_IDLE;
        end else if (timeout_hit) begin
          fault_d                 = 1'b1;
          fault_core_d            = efi_core_id_q;
          pend_clr[efi_core_id_q] = 1'b1;
          rr_ptr_d                = next_ptr;
          state_d                 = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          fault_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request on the cycle its previous one retires re-arms the bit.
    pending_d = (pending_q & ~pend_clr) | efi_if.core_efi_start;
    busy_d    = (state_d == ST_GRANT) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      pending_q       <= '0;
      rr_ptr_q        <= '0;
      efi_core_id_q   <= '0;
      counter_q       <= '0;
      core_efi_done_q <= '0;
      busy_q          <= 1'b0;
      fault_q         <= 1'b0;
      fault_core_q    <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      rr_ptr_q        <= rr_ptr_d;
      efi_core_id_q   <= efi_core_id_d;
      counter_q       <= counter_d;
      core_efi_done_q <= core_efi_done_d;
      busy_q          <= busy_d;
      fault_q         <= fault_d;
      fault_core_q    <= fault_core_d;
    end
  end

  assign efi_if.efi_start     = (state_q == ST_GRANT);
  assign efi_if.efi_core_id   = efi_core_id_q;
  assign efi_if.core_efi_done = core_efi_done_q;
  assign busy                 = busy_q;
  assign fault                = fault_q;
  assign fault_core           = fault_core_q;
endmodule

// File: doc/fcore_efi_arbiter.md
Name: fcore_efi_arbiter

Overview:
- Shares one Extended Function Interface (EFI) unit between N_CORES fCore control units.
- Each core raises an EFI request pulse from its EFI_CALL state and stalls until it receives a done pulse.
- The arbiter queues requests, grants them round-robin, forwards start/done, and tags the EFI unit with the owning core index.
- A watchdog converts a hung EFI unit into a sticky fault instead of a permanent stall.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- TIMEOUT_WIDTH, 16, width of the watchdog counter and of timeout_cycles.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- core_efi_start  in  N_CORES  per-core single-cycle EFI request pulse.
- core_efi_done  out  N_CORES  per-core single-cycle completion pulse.
- efi_start  out  1  single-cycle start pulse to the shared EFI unit.
- efi_done  in  1  completion pulse from the EFI unit.
- efi_core_id  out  $clog2(N_CORES)  index of the granted core; stable from efi_start until completion.
- timeout_cycles  in  TIMEOUT_WIDTH  watchdog limit; 0 disables the watchdog.
- clear_fault  in  1  pulse: leave FAULT.
- busy  out  1  high in GRANT and WAIT.
- fault  out  1  sticky timeout flag.
- fault_core  out  $clog2(N_CORES)  core that was granted when the timeout fired.

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0, pending=0, rr_ptr=0, counter=0, state=IDLE. This applies mid-transaction too; an in-flight EFI op is abandoned and its done is never forwarded.
- pending[N_CORES] register:
  - Bit i is set on core_efi_start[i].
  - Bit i is cleared when core i is completed or timed out.
  - A set and a clear on the same bit in the same cycle: set wins.
- States: IDLE, GRANT, WAIT, FAULT.
- IDLE:
  - If pending!=0, select the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap modulo N_CORES.
  - Register the selection into efi_core_id and go to GRANT.
  - The scan uses the registered pending, so a start at cycle t can be granted at t+1 at the earliest.
- GRANT:
  - efi_start=1 for exactly this cycle; counter=0; go to WAIT.
  - Minimum latency, core_efi_start to efi_start: 2 cycles.
- WAIT:
  - counter increments every cycle, saturating at all-ones.
  - On efi_done: core_efi_done[efi_core_id]=1 on the next cycle (exactly 1 cycle), clear pending[efi_core_id], rr_ptr=efi_core_id+1 (wrap to 0 at N_CORES), go to IDLE.
  - Timeout: when timeout_cycles!=0 and counter==timeout_cycles-1 with no efi_done that cycle:
    - fault=1, fault_core=efi_core_id.
    - Clear pending[efi_core_id]; no done pulse to that core.
    - rr_ptr advances as for a completion; go to FAULT.
  - efi_done in the same cycle as the timeout condition: done wins, no fault.
- FAULT:
  - No grants. Requests keep accumulating in pending.
  - On clear_fault: fault=0, go to IDLE. fault_core holds its value until the next fault.
- efi_done outside WAIT is ignored. A core_efi_start from a core whose pending bit is already set is absorbed (no double grant).
- busy is registered: 1 in GRANT and WAIT, 0 otherwise.
- Only one EFI operation is outstanding at any time.
- Expected RTL size: roughly 150–250 lines.

Test Plan:
- Single request, N_CORES=4, timeout_cycles=0: core_efi_start[2] at t=10 -> efi_start at t=12 with efi_core_id=2; efi_done at t=20 -> core_efi_done=4'b0100 at t=21 only; busy high t=12..20.
- Simultaneous requests: core_efi_start=4'b1011 in one cycle, rr_ptr=0, EFI unit answers 3 cycles after each start -> grant order 0, 1, 3; then a new request from core 0 with 3 pending -> 3 is served before 0.
- Timeout: timeout_cycles=5, core 1 granted, efi_done never asserted -> fault=1 and fault_core=1 on the 5th WAIT cycle, no core_efi_done[1]; core 2 request made during FAULT is not granted until clear_fault, then efi_start follows within 2 cycles.
- Race at limit: timeout_cycles=5, efi_done asserted exactly on the 5th WAIT cycle -> core_efi_done pulse, fault stays 0.
- Reset mid-operation: reset=0 during WAIT with 2 pending -> all outputs 0, pending cleared; a late efi_done after reset release produces no core_efi_done.
- Duplicate request: core 3 pulses core_efi_start twice while pending -> exactly one efi_start and one core_efi_done for core 3.
